// File: rtl/imc_pkg.sv
// rtl/imc_pkg.sv - shared result codes, FSM states and word field positions
package imc_pkg;

  localparam logic [1:0] RES_READ = 2'b01;
  localparam logic [1:0] RES_MAC  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_MAC_COLLECT = 2'd1,
    ST_MAC_FLUSH   = 2'd2
  } state_t;

  localparam int TYPE_MSB = 31;
  localparam int TYPE_LSB = 30;
  localparam int CNT_MSB  = 29;
  localparam int CNT_LSB  = 28;
  localparam int TAG_MSB  = 27;
  localparam int TAG_LSB  = 24;
  localparam int CSA_BIT  = 8;
  localparam int ROW_MSB  = 7;
  localparam int ROW_LSB  = 4;
  localparam int COL_MSB  = 3;
  localparam int COL_LSB  = 0;

  localparam int ADC_BITS_DEFAULT = 6;
  localparam int SAMPLES_PER_WORD = 4;

endpackage

// File: rtl/result_fifo.sv
// rtl/result_fifo.sv - synchronous result FIFO with registered read and sticky drop flag
module result_fifo #(
  parameter int WIDTH = 32,
  parameter int ADDR  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop_req,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  input  logic             overflow_clr
);

  localparam int DEPTH = 1 << ADDR;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [ADDR-1:0]  wptr, rptr;
  logic [ADDR:0]    count;
  logic             pop, wr, drop;

  assign empty = (count == '0);
  assign full  = (count == (ADDR+1)'(DEPTH));
  // A pop on an empty buffer is meaningless, so it never frees room for a push
  assign pop   = pop_req && !empty;
  assign wr    = push && (!full || pop);
  assign drop  = push && full && !pop;

  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      pop_data <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr) wptr <= wptr + 1'b1;
      if (pop) begin
        pop_data <= mem[rptr];
        rptr     <= rptr + 1'b1;
      end
      case ({wr, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop)              overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;
    end
  end

endmodule

// File: rtl/imc_result_collector.sv
// rtl/imc_result_collector.sv - packs CSA reads and ADC MAC samples into result words
// Optional RESULT_TAG_EN adds row/column tags to read words and column tags to MAC words.
module imc_result_collector
  import imc_pkg::*;
#(
  parameter int INSTRUCTION_SIZE = 32,
  parameter int ADC_BITS         = ADC_BITS_DEFAULT,
  parameter int ADDR_SIZE_OB     = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        read_valid,
  input  logic [3:0]                  read_col,
  input  logic [3:0]                  read_row,
  input  logic                        csa_out1,
  input  logic                        csa_out2,
  input  logic                        mac_start,
  input  logic [3:0]                  mac_col_start,
  input  logic                        adc_valid,
  input  logic [ADC_BITS-1:0]         adc_data,
  input  logic                        mac_done,
  input  logic                        wishbone_rd_cs_output_buffer,
  input  logic                        wishbone_rd_en_output_buffer,
  output logic [INSTRUCTION_SIZE-1:0] wishbone_databus_out,
  output logic                        wishbone_empty_output_buffer,
  output logic                        wishbone_full_output_buffer,
  output logic                        overflow,
  input  logic                        overflow_clr,
  output logic                        busy
);

  localparam int PACK_W = SAMPLES_PER_WORD * ADC_BITS;

  state_t                        state_q, state_d;
  logic [1:0]                    cnt_q;
  logic [PACK_W-1:0]             samples_q, samples_next;
  logic                          read_fire, append, word_full, flush_push;
  logic                          push;
  logic [INSTRUCTION_SIZE-1:0]   read_word, mac_word, push_data;

`ifdef RESULT_TAG_EN
  // Column of sample 0 of the word currently being packed
  logic [3:0] col_q;
`else
  logic unused_tag_inputs;
  assign unused_tag_inputs = ^{read_row, mac_col_start};
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:        if (mac_start) state_d = ST_MAC_COLLECT;
      ST_MAC_COLLECT: if (mac_done)  state_d = ST_MAC_FLUSH;
      ST_MAC_FLUSH:                  state_d = ST_IDLE;
      default:                       state_d = ST_IDLE;
    endcase
  end

  assign busy       = (state_q != ST_IDLE);
  assign read_fire  = (state_q == ST_IDLE) && read_valid;
  assign append     = (state_q == ST_MAC_COLLECT) && adc_valid;
  assign word_full  = append && (cnt_q == 2'd3);
  assign flush_push = (state_q == ST_MAC_FLUSH) && (cnt_q != 2'd0);

  always_comb begin
    samples_next = samples_q;
    if (append) begin
      for (int k = 0; k < SAMPLES_PER_WORD; k++) begin
        if (cnt_q == 2'(k)) samples_next[k*ADC_BITS +: ADC_BITS] = adc_data;
      end
    end
  end

  always_comb begin
    read_word = '0;
    read_word[TYPE_MSB:TYPE_LSB] = RES_READ;
    read_word[CSA_BIT] = (read_col < 4'd8) ? csa_out1 : csa_out2;
`ifdef RESULT_TAG_EN
    read_word[ROW_MSB:ROW_LSB] = read_row;
    read_word[COL_MSB:COL_LSB] = read_col;
`endif
  end

  // Samples never change during MAC_FLUSH, so samples_next serves both push paths
  always_comb begin
    mac_word = '0;
    mac_word[TYPE_MSB:TYPE_LSB] = RES_MAC;
    mac_word[CNT_MSB:CNT_LSB]   = word_full ? 2'd3 : (cnt_q - 2'd1);
`ifdef RESULT_TAG_EN
    mac_word[TAG_MSB:TAG_LSB]   = col_q;
`endif
    mac_word[PACK_W-1:0]        = samples_next;
  end

  assign push      = read_fire || word_full || flush_push;
  assign push_data = read_fire ? read_word : mac_word;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      samples_q <= '0;
`ifdef RESULT_TAG_EN
      col_q     <= '0;
`endif
    end else if (state_q == ST_IDLE) begin
      cnt_q     <= '0;
      samples_q <= '0;
`ifdef RESULT_TAG_EN
      if (mac_start) col_q <= mac_col_start;
`endif
    end else if (word_full) begin
      cnt_q     <= '0;
      samples_q <= '0;
`ifdef RESULT_TAG_EN
      col_q     <= col_q + 4'd4;
`endif
    end else if (append) begin
      cnt_q     <= cnt_q + 2'd1;
      samples_q <= samples_next;
    end else if (state_q == ST_MAC_FLUSH) begin
      cnt_q     <= '0;
      samples_q <= '0;
    end
  end

  result_fifo #(
    .WIDTH (INSTRUCTION_SIZE),
    .ADDR  (ADDR_SIZE_OB)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push         (push),
    .push_data    (push_data),
    .pop_req      (wishbone_rd_cs_output_buffer && wishbone_rd_en_output_buffer),
    .pop_data     (wishbone_databus_out),
    .empty        (wishbone_empty_output_buffer),
    .full         (wishbone_full_output_buffer),
    .overflow     (overflow),
    .overflow_clr (overflow_clr)
  );

endmodule

// File: tb/tb_imc_result_collector.sv
// tb/tb_imc_result_collector.sv - directed and randomized checks against a queue-based result model
module tb_imc_result_collector;

  localparam int IS = 32;
  localparam int AB = 6;
  localparam int AO = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          read_valid = 1'b0;
  logic [3:0]    read_col = '0;
  logic [3:0]    read_row = '0;
  logic          csa_out1 = 1'b0;
  logic          csa_out2 = 1'b0;
  logic          mac_start = 1'b0;
  logic [3:0]    mac_col_start = '0;
  logic          adc_valid = 1'b0;
  logic [AB-1:0] adc_data = '0;
  logic          mac_done = 1'b0;
  logic          rd_cs = 1'b0;
  logic          rd_en = 1'b0;
  logic [IS-1:0] databus;
  logic          empty, full, overflow, busy;
  logic          overflow_clr = 1'b0;

  imc_result_collector #(.INSTRUCTION_SIZE(IS), .ADC_BITS(AB), .ADDR_SIZE_OB(AO)) dut (
    .clk                          (clk),
    .rst                          (rst),
    .read_valid                   (read_valid),
    .read_col                     (read_col),
    .read_row                     (read_row),
    .csa_out1                     (csa_out1),
    .csa_out2                     (csa_out2),
    .mac_start                    (mac_start),
    .mac_col_start                (mac_col_start),
    .adc_valid                    (adc_valid),
    .adc_data                     (adc_data),
    .mac_done                     (mac_done),
    .wishbone_rd_cs_output_buffer (rd_cs),
    .wishbone_rd_en_output_buffer (rd_en),
    .wishbone_databus_out         (databus),
    .wishbone_empty_output_buffer (empty),
    .wishbone_full_output_buffer  (full),
    .overflow                     (overflow),
    .overflow_clr                 (overflow_clr),
    .busy                         (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [31:0]   mq[$];
  logic [AB-1:0] stim[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_read(input logic [3:0] row, input logic [3:0] col,
                                           input logic c1, input logic c2);
    logic [31:0] w;
    w = 32'h4000_0000;
    w[8] = (col < 4'd8) ? c1 : c2;
`ifdef RESULT_TAG_EN
    w[7:0] = {row, col};
`endif
    return w;
  endfunction

  task automatic model_push(input logic [31:0] w);
    if (mq.size() < DEPTH) mq.push_back(w);
  endtask

  task automatic do_read(input logic [3:0] row, input logic [3:0] col,
                         input logic c1, input logic c2, input bit with_pop);
    read_row = row; read_col = col; csa_out1 = c1; csa_out2 = c2;
    read_valid = 1'b1;
    rd_cs = with_pop; rd_en = with_pop;
    tick();
    read_valid = 1'b0; rd_cs = 1'b0; rd_en = 1'b0;
  endtask

  task automatic rand_read();
    logic [3:0] r, c;
    logic a, b;
    r = 4'($urandom); c = 4'($urandom); a = 1'($urandom); b = 1'($urandom);
    do_read(r, c, a, b, 1'b0);
    model_push(exp_read(r, c, a, b));
  endtask

  task automatic pop_exp(input string tag, input logic [31:0] exp);
    rd_cs = 1'b1; rd_en = 1'b1;
    tick();
    rd_cs = 1'b0; rd_en = 1'b0;
    chk(tag, databus, exp);
  endtask

  task automatic drain(input string tag);
    while (mq.size() > 0) pop_exp(tag, mq.pop_front());
    chk({tag, "_empty"}, 32'(empty), 32'd1);
  endtask

  // Drives one MAC collection with the samples in stim and appends the expected words to mq
  task automatic run_mac(input logic [3:0] col, input bit done_with_last, input bit inject);
    int n, m;
    logic [31:0] w;
    n = stim.size();
    mac_start = 1'b1; mac_col_start = col;
    tick();
    mac_start = 1'b0;
    chk("mac_busy", 32'(busy), 32'd1);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        if (inject) begin
          read_valid = 1'b1; read_row = 4'($urandom); read_col = 4'($urandom);
          mac_start = 1'b1; mac_col_start = 4'($urandom);
        end
        tick();
        read_valid = 1'b0; mac_start = 1'b0;
      end
      adc_valid = 1'b1; adc_data = stim[i];
      if (done_with_last && i == n - 1) mac_done = 1'b1;
      tick();
      adc_valid = 1'b0; mac_done = 1'b0;
    end
    if (!(done_with_last && n > 0)) begin
      mac_done = 1'b1;
      tick();
      mac_done = 1'b0;
    end
    tick();
    chk("mac_idle", 32'(busy), 32'd0);
    for (int wi = 0; 4 * wi < n; wi++) begin
      m = (n - 4 * wi > 4) ? 4 : n - 4 * wi;
      w = 32'h8000_0000;
      w[29:28] = 2'(m - 1);
`ifdef RESULT_TAG_EN
      w[27:24] = 4'(int'(col) + 4 * wi);
`endif
      for (int j = 0; j < m; j++) w[AB*j +: AB] = stim[4*wi + j];
      model_push(w);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held, popped;

    tick(); tick();
    rst = 1'b0;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_databus", databus, 32'd0);

    // single-cell reads: column in CSA1 half and in CSA2 half
    do_read(4'd5, 4'd3, 1'b1, 1'b0, 1'b0);
    chk("read1_empty", 32'(empty), 32'd0);
`ifdef RESULT_TAG_EN
    pop_exp("read1_word", 32'h4000_0153);
`else
    pop_exp("read1_word", 32'h4000_0100);
`endif
    do_read(4'd5, 4'd9, 1'b1, 1'b0, 1'b0);
`ifdef RESULT_TAG_EN
    pop_exp("read2_word", 32'h4000_0059);
`else
    pop_exp("read2_word", 32'h4000_0000);
`endif
    chk("read2_empty", 32'(empty), 32'd1);

    // five samples from column 14: full word then a one-sample wrapped word
    stim.delete();
    for (int i = 1; i <= 5; i++) stim.push_back(AB'(i));
    run_mac(4'd14, 1'b0, 1'b0);
    mq.delete();
`ifdef RESULT_TAG_EN
    pop_exp("mac14_w0", 32'hBE10_3081);
    pop_exp("mac14_w1", 32'h8200_0005);
`else
    pop_exp("mac14_w0", 32'hB010_3081);
    pop_exp("mac14_w1", 32'h8000_0005);
`endif
    chk("mac14_empty", 32'(empty), 32'd1);

    // fourth sample coincident with mac_done yields exactly one word
    stim.delete();
    for (int i = 0; i < 4; i++) stim.push_back(AB'($urandom));
    run_mac(4'($urandom), 1'b1, 1'b0);
    chk("done4_count", 32'(mq.size()), 32'd1);
    drain("done4");

    // randomized MAC collections with ignored read/mac_start pulses, interleaved with reads
    for (int t = 0; t < 25; t++) begin
      stim.delete();
      for (int i = 0; i < $urandom_range(0, 10); i++) stim.push_back(AB'($urandom));
      run_mac(4'($urandom), 1'($urandom), 1'b1);
      for (int r = 0; r < $urandom_range(0, 3); r++) rand_read();
      drain("rand_mac");
    end

    // fill, then one dropped push
    for (int i = 0; i < DEPTH; i++) rand_read();
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_no_ovf", 32'(overflow), 32'd0);
    rand_read();
    chk("drop_ovf", 32'(overflow), 32'd1);
    drain("drop_contents");
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    chk("ovf_clr", 32'(overflow), 32'd0);

    // fill, then push with a simultaneous pop: both succeed
    for (int i = 0; i < DEPTH; i++) rand_read();
    popped = mq.pop_front();
    do_read(4'd7, 4'd12, 1'b0, 1'b1, 1'b1);
    mq.push_back(exp_read(4'd7, 4'd12, 1'b0, 1'b1));
    chk("pushpop_data", databus, popped);
    chk("pushpop_no_ovf", 32'(overflow), 32'd0);
    chk("pushpop_full", 32'(full), 32'd1);

    // drop and clear together: drop wins
    overflow_clr = 1'b1;
    rand_read();
    overflow_clr = 1'b0;
    chk("drop_vs_clr", 32'(overflow), 32'd1);
    drain("pushpop_contents");

    // push with a pop on an empty buffer: word stored, bus holds
    held = databus;
    do_read(4'd2, 4'd1, 1'b1, 1'b1, 1'b1);
    model_push(exp_read(4'd2, 4'd1, 1'b1, 1'b1));
    chk("empty_pop_stored", 32'(empty), 32'd0);
    chk("empty_pop_hold", databus, held);
    drain("empty_pop");

    // reset in the middle of a collection discards the partial word
    mac_start = 1'b1; mac_col_start = 4'd3;
    tick();
    mac_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      adc_valid = 1'b1; adc_data = AB'($urandom);
      tick();
    end
    adc_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_empty", 32'(empty), 32'd1);
    chk("midrst_ovf", 32'(overflow), 32'd0);
    mac_done = 1'b1;
    tick();
    mac_done = 1'b0;
    tick(); tick();
    chk("midrst_no_word", 32'(empty), 32'd1);
    chk("midrst_still_idle", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
